// File: rtl/relfet_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// relfet_bus_arbiter_if
// Bundle of every signal exchanged between the two-master bus arbiter and
// its environment (the two masters plus the shared, OR-combined slave bus).
//
// Handshake: a master raises mx_req and keeps it high for as long as it wants
// the bus; mx_grant high means "this master owns the bus in this cycle", and
// only in such a cycle are its address/data/write strobe forwarded onto the
// shared bus. Read data for an address owned in cycle t arrives on
// bus_data_in in cycle t+1 and is routed back to the master that owned t.
//
// Modports:
//   master - the arbiter side; it drives the shared slave bus and the grants.
//   slave  - the environment side (masters and slaves driving the inputs).
// ---------------------------------------------------------------------------
interface relfet_bus_arbiter_if #(
    parameter int wordsize = 8
);
    logic                m0_req;
    logic                m1_req;
    logic [wordsize-1:0] m0_addr;
    logic [wordsize-1:0] m1_addr;
    logic [wordsize-1:0] m0_data_out;
    logic [wordsize-1:0] m1_data_out;
    logic                m0_write_en;
    logic                m1_write_en;
    logic                m0_grant;
    logic                m1_grant;
    logic [wordsize-1:0] m0_data_in;
    logic [wordsize-1:0] m1_data_in;
    logic [wordsize-1:0] bus_addr;
    logic [wordsize-1:0] bus_data_out;
    logic                bus_write_en;
    logic [wordsize-1:0] bus_data_in;

    modport master (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_data_out, m1_data_out,
        input  m0_write_en, m1_write_en, bus_data_in,
        output m0_grant, m1_grant, m0_data_in, m1_data_in,
        output bus_addr, bus_data_out, bus_write_en
    );

    modport slave (
        output m0_req, m1_req, m0_addr, m1_addr, m0_data_out, m1_data_out,
        output m0_write_en, m1_write_en, bus_data_in,
        input  m0_grant, m1_grant, m0_data_in, m1_data_in,
        input  bus_addr, bus_data_out, bus_write_en
    );
endinterface

// File: rtl/relfet_bus_arbiter.sv
// ---------------------------------------------------------------------------
// relfet_bus_arbiter
// Two-master arbiter for a shared slave bus. Ownership is granted one cycle
// after a request is seen in IDLE; a master may keep the bus for up to
// max_burst consecutive cycles while the other one waits, then ownership is
// handed over without a dead cycle. Ties from IDLE go to the master that was
// not served last. Read data is routed using the owner of the previous cycle
// so that it follows its address across an ownership switch.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active low (0 = reset)
//   bus       - relfet_bus_arbiter_if.master: requests, master write data,
//               grants, returned read data and the shared slave bus
//   state_dbg - current FSM state (0 IDLE, 1 OWN0, 2 OWN1)
// ---------------------------------------------------------------------------
module relfet_bus_arbiter #(
    parameter int wordsize  = 8,
    parameter int max_burst = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    relfet_bus_arbiter_if.master bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_t;

    localparam logic [7:0] max_cnt = 8'(max_burst);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    owner_t     owner_dly_q, owner_dly_d;

    logic own0;
    logic own1;

    // Next-state, burst counter and last-served bookkeeping.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        owner_dly_d = OWNER_NONE;

        case (state_q)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.m0_req) begin
                    state_d = OWN0;
                end else if (bus.m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                owner_dly_d = OWNER_M0;
                // A dropped request takes priority over burst expiry; both
                // lead to the same place when the other master is waiting.
                if (!bus.m0_req) begin
                    state_d = bus.m1_req ? OWN1 : IDLE;
                end else if (bus.m1_req && (cnt_q == max_cnt)) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                owner_dly_d = OWNER_M1;
                if (!bus.m1_req) begin
                    state_d = bus.m0_req ? OWN0 : IDLE;
                end else if (bus.m0_req && (cnt_q == max_cnt)) begin
                    state_d = OWN0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh ownership restarts the burst count; a continuing one
        // counts up and saturates so a lone owner never expires.
        if (state_d != state_q) begin
            if (state_d == OWN0) begin
                cnt_d  = 8'd1;
                last_d = 1'b0;
            end else if (state_d == OWN1) begin
                cnt_d  = 8'd1;
                last_d = 1'b1;
            end
        end else if ((state_q != IDLE) && (cnt_q != max_cnt)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= 8'd0;
            owner_dly_q <= OWNER_NONE;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            owner_dly_q <= owner_dly_d;
        end
    end

    // Everything visible is forced to zero while reset is low, so a reset
    // arriving mid-burst kills the grant and the write strobe immediately.
    assign own0 = reset && (state_q == OWN0);
    assign own1 = reset && (state_q == OWN1);

    assign bus.m0_grant     = own0;
    assign bus.m1_grant     = own1;
    assign bus.bus_addr     = own0 ? bus.m0_addr :
                              own1 ? bus.m1_addr : '0;
    assign bus.bus_data_out = own0 ? bus.m0_data_out :
                              own1 ? bus.m1_data_out : '0;
    assign bus.bus_write_en = own0 ? bus.m0_write_en :
                              own1 ? bus.m1_write_en : 1'b0;

    assign bus.m0_data_in = (reset && (owner_dly_q == OWNER_M0)) ? bus.bus_data_in : '0;
    assign bus.m1_data_in = (reset && (owner_dly_q == OWNER_M1)) ? bus.bus_data_in : '0;

    assign state_dbg = state_q;

endmodule

// File: tb/tb_relfet_bus_arbiter.sv
module tb_relfet_bus_arbiter;

    localparam int W   = 8;
    localparam int MB0 = 4;
    localparam int MB1 = 1;
    localparam int EW  = 3 + 4 * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    relfet_bus_arbiter_if #(.wordsize(W)) a_if ();
    relfet_bus_arbiter_if #(.wordsize(W)) b_if ();

    // second instance (max_burst = 1) sees exactly the same inputs
    assign b_if.m0_req      = a_if.m0_req;
    assign b_if.m1_req      = a_if.m1_req;
    assign b_if.m0_addr     = a_if.m0_addr;
    assign b_if.m1_addr     = a_if.m1_addr;
    assign b_if.m0_data_out = a_if.m0_data_out;
    assign b_if.m1_data_out = a_if.m1_data_out;
    assign b_if.m0_write_en = a_if.m0_write_en;
    assign b_if.m1_write_en = a_if.m1_write_en;
    assign b_if.bus_data_in = a_if.bus_data_in;

    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    relfet_bus_arbiter #(.wordsize(W), .max_burst(MB0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (a_if.master),
        .state_dbg (dbg_a)
    );

    relfet_bus_arbiter #(.wordsize(W), .max_burst(MB1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (b_if.master),
        .state_dbg (dbg_b)
    );

    // ---------------- reference model ----------------
    // owner: -1 none, 0/1 master; run: consecutive cycles owned so far;
    // last: most recently served master; prev: owner of the previous cycle.
    typedef struct {
        int owner;
        int run;
        int last;
        int prev;
    } model_t;

    model_t ma = '{owner: -1, run: 0, last: 1, prev: -1};
    model_t mb = '{owner: -1, run: 0, last: 1, prev: -1};

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp1_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [EW-1:0] model_out(input model_t m);
        logic g0, g1, we;
        logic [W-1:0] ad, dout, d0, d1;
        g0 = 1'b0; g1 = 1'b0; we = 1'b0;
        ad = '0; dout = '0; d0 = '0; d1 = '0;
        if (reset) begin
            if (m.owner == 0) begin
                g0 = 1'b1; ad = a_if.m0_addr; dout = a_if.m0_data_out; we = a_if.m0_write_en;
            end else if (m.owner == 1) begin
                g1 = 1'b1; ad = a_if.m1_addr; dout = a_if.m1_data_out; we = a_if.m1_write_en;
            end
            if (m.prev == 0) d0 = a_if.bus_data_in;
            if (m.prev == 1) d1 = a_if.bus_data_in;
        end
        return {g0, g1, we, ad, dout, d0, d1};
    endfunction

    function automatic model_t model_next(input model_t m, input int max_b);
        model_t n;
        bit r[2];
        int want;
        int o;
        int p;
        n = m;
        if (!reset) begin
            n.owner = -1; n.run = 0; n.last = 1; n.prev = -1;
            return n;
        end
        r[0] = a_if.m0_req;
        r[1] = a_if.m1_req;
        n.prev = m.owner;
        if (m.owner < 0) begin
            if (r[0] && r[1]) want = 1 - m.last;
            else if (r[0])    want = 0;
            else if (r[1])    want = 1;
            else              want = -1;
        end else begin
            o = m.owner;
            p = 1 - o;
            if (!r[o])                      want = r[p] ? p : -1;
            else if (r[p] && m.run >= max_b) want = p;
            else                             want = o;
        end
        if (want < 0)             n.run = 0;
        else if (want == m.owner) n.run = m.run + 1;
        else begin
            n.run  = 1;
            n.last = want;
        end
        n.owner = want;
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst_n, input logic r0, input logic r1,
                         input logic w0, input logic w1,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] bdi);
        @(posedge clk);
        #1;
        reset            = rst_n;
        a_if.m0_req      = r0;
        a_if.m1_req      = r1;
        a_if.m0_write_en = w0;
        a_if.m1_write_en = w1;
        a_if.m0_addr     = a0;
        a_if.m1_addr     = a1;
        a_if.m0_data_out = d0;
        a_if.m1_data_out = d1;
        a_if.bus_data_in = bdi;
        exp_q.push_back(model_out(ma));
        exp1_q.push_back(model_out(mb));
        ma = model_next(ma, MB0);
        mb = model_next(mb, MB1);
    endtask

    task automatic rstep(input logic rst_n, input logic r0, input logic r1,
                         input logic w0, input logic w1);
        drive(rst_n, r0, r1, w0, w1, W'($urandom), W'($urandom),
              W'($urandom), W'($urandom), W'($urandom));
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] e_a, e_b, act_a, act_b;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_a   = exp_q.pop_front();
            act_a = {a_if.m0_grant, a_if.m1_grant, a_if.bus_write_en, a_if.bus_addr,
                     a_if.bus_data_out, a_if.m0_data_in, a_if.m1_data_in};
            n_cmp++;
            if (act_a !== e_a) begin
                n_err++;
                $display("FAIL sb_mb4 t=%0t got=%h expected=%h", $time, act_a, e_a);
            end
            n_cmp++;
            if (a_if.m0_grant && a_if.m1_grant) begin
                n_err++;
                $display("FAIL grant_excl t=%0t got=11 expected=not both", $time);
            end
        end
        if (exp1_q.size() > 0) begin
            e_b   = exp1_q.pop_front();
            act_b = {b_if.m0_grant, b_if.m1_grant, b_if.bus_write_en, b_if.bus_addr,
                     b_if.bus_data_out, b_if.m0_data_in, b_if.m1_data_in};
            n_cmp++;
            if (act_b !== e_b) begin
                n_err++;
                $display("FAIL sb_mb1 t=%0t got=%h expected=%h", $time, act_b, e_b);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        a_if.m0_req = 1'b0; a_if.m1_req = 1'b0;
        a_if.m0_write_en = 1'b0; a_if.m1_write_en = 1'b0;
        a_if.m0_addr = '0; a_if.m1_addr = '0;
        a_if.m0_data_out = '0; a_if.m1_data_out = '0;
        a_if.bus_data_in = '0;

        // reset state, with junk on the inputs
        repeat (3) rstep(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // tie after reset: m0 first, then alternating bursts
        repeat (20) rstep(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // read routing and drop-and-handoff
        rstep(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstep(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h11, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h11, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h22, 8'h00, 8'h00, 8'h64);
        rstep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rstep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // write gating: strobe without request, then granted write of 0x07
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h40, 8'h00, 8'h07, 8'h00);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h40, 8'h00, 8'h07, 8'h00);
        rstep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // solo owner: 20 cycles of m0 alone, no expiry
        repeat (20) rstep(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        rstep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-burst in the second cycle of OWN1, then tie on release
        rstep(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        rstep(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        rstep(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (6) rstep(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            rstep(logic'($urandom_range(0, 63) != 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)));
        end

        // drain the scoreboard and make sure every expectation was consumed
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got=%0d/%0d left expected=0/0", exp_q.size(), exp1_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
